// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared types and encodings for the L2 cache control FSM.
//   l2_state_e   - controller state encoding (prefetch states only exist when
//                  L2_CACHE_PREFETCH_EN is defined)
//   Paddr*       - encodings driven on paddr_sel to pick the downstream address
package l2_cache_pkg;

`ifdef L2_CACHE_PREFETCH_EN
  typedef enum logic [3:0] {
    StIdle,
    StLookup,
    StDecide,
    StWriteback,
    StFill,
    StPfLookup,
    StPfDecide,
    StPfWriteback,
    StPfFill
  } l2_state_e;
`else
  typedef enum logic [3:0] {
    StIdle,
    StLookup,
    StDecide,
    StWriteback,
    StFill
  } l2_state_e;
`endif

  localparam logic [1:0] PaddrCpu      = 2'd0;
  localparam logic [1:0] PaddrVictim   = 2'd1;
  localparam logic [1:0] PaddrPrefetch = 2'd2;

endpackage

// File: rtl/l2_way_encode.sv
// l2_way_encode: converts a per-way hit vector into a way index.
//   onehot_i - per-way match flags (WAYS bits)
//   idx_o    - index of the lowest set bit (0 when none set)
//   any_o    - at least one bit set
//   multi_o  - more than one bit set
module l2_way_encode #(
  parameter int unsigned WAYS = 4,
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0]  onehot_i,
  output logic [WAY_W-1:0] idx_o,
  output logic             any_o,
  output logic             multi_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (onehot_i[i]) idx_o = WAY_W'(i);
    end
  end

  assign any_o   = |onehot_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(onehot_i & (onehot_i - WAYS'(1)));

endmodule

// File: rtl/l2_cache_fsm.sv
// l2_cache_fsm: L2 cache controller FSM (lookup, writeback, fill, optional prefetch).
// Build option: define L2_CACHE_PREFETCH_EN to add next-line prefetch after a
// demand fill; otherwise the prefetch states are absent and pf_addr_load is 0.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   mem_read, mem_write     - upstream request, held until mem_resp
//   mem_resp                - one-cycle upstream completion pulse
//   pmem_read, pmem_write   - downstream request, held until pmem_resp
//   pmem_resp               - downstream completion
//   hit_way, dirty_way      - per-way tag-match and dirty flags
//   lru_way                 - victim way from the LRU array
//   way_sel                 - way targeted by array loads
//   data/tag/valid/dirty/lru_load - array write strobes
//   dirty_in, data_in_sel   - dirty value written; data source (0 CPU, 1 pmem)
//   paddr_sel               - downstream address source (cpu/victim/prefetch)
//   pf_addr_load            - latch next-line address
//   multi_hit               - multi-way hit error pulse
// All outputs are registered: they reflect the state entered at the last edge.
module l2_cache_fsm
  import l2_cache_pkg::*;
#(
  parameter int unsigned WAYS = 4,
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  input  logic             pmem_resp,
  input  logic [WAYS-1:0]  hit_way,
  input  logic [WAYS-1:0]  dirty_way,
  input  logic [WAY_W-1:0] lru_way,
  output logic [WAY_W-1:0] way_sel,
  output logic             data_load,
  output logic             tag_load,
  output logic             valid_load,
  output logic             dirty_load,
  output logic             lru_load,
  output logic             dirty_in,
  output logic             data_in_sel,
  output logic [1:0]       paddr_sel,
  output logic             pf_addr_load,
  output logic             multi_hit
);

  l2_state_e        state_q;
  logic [WAY_W-1:0] victim_q;
  logic             is_write_q;
  logic             dropped_q;

  logic [WAY_W-1:0] hit_idx;
  logic             hit_any;
  logic             hit_multi;
  logic             req_now;
  logic             req_live;

  l2_way_encode #(
    .WAYS (WAYS)
  ) u_way_encode (
    .onehot_i (hit_way),
    .idx_o    (hit_idx),
    .any_o    (hit_any),
    .multi_o  (hit_multi)
  );

  assign req_now  = mem_read | mem_write;
  // A request that went away mid-transaction still finishes its fill silently.
  assign req_live = req_now & ~dropped_q;

`ifdef L2_CACHE_PREFETCH_EN
  logic pf_pending_q;
  logic pf_addr_load_q;
  assign pf_addr_load = pf_addr_load_q;
`else
  assign pf_addr_load = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      victim_q    <= '0;
      is_write_q  <= 1'b0;
      dropped_q   <= 1'b0;
      mem_resp    <= 1'b0;
      pmem_read   <= 1'b0;
      pmem_write  <= 1'b0;
      way_sel     <= '0;
      data_load   <= 1'b0;
      tag_load    <= 1'b0;
      valid_load  <= 1'b0;
      dirty_load  <= 1'b0;
      lru_load    <= 1'b0;
      dirty_in    <= 1'b0;
      data_in_sel <= 1'b0;
      paddr_sel   <= PaddrCpu;
      multi_hit   <= 1'b0;
`ifdef L2_CACHE_PREFETCH_EN
      pf_pending_q   <= 1'b0;
      pf_addr_load_q <= 1'b0;
`endif
    end else begin
      // Everything defaults low; each branch re-asserts what the next state holds.
      mem_resp    <= 1'b0;
      pmem_read   <= 1'b0;
      pmem_write  <= 1'b0;
      way_sel     <= '0;
      data_load   <= 1'b0;
      tag_load    <= 1'b0;
      valid_load  <= 1'b0;
      dirty_load  <= 1'b0;
      lru_load    <= 1'b0;
      dirty_in    <= 1'b0;
      data_in_sel <= 1'b0;
      paddr_sel   <= PaddrCpu;
      multi_hit   <= 1'b0;
`ifdef L2_CACHE_PREFETCH_EN
      pf_addr_load_q <= 1'b0;
`endif

      unique case (state_q)
        StIdle: begin
          // The cycle carrying mem_resp is the last one of the old request.
          if (req_now && !mem_resp) begin
            state_q    <= StLookup;
            is_write_q <= mem_write;
            dropped_q  <= 1'b0;
          end
        end

        StLookup: begin
          if (!req_now) dropped_q <= 1'b1;
          state_q <= StDecide;
        end

        StDecide: begin
          if (!req_now) dropped_q <= 1'b1;
          if (hit_any) begin
            way_sel   <= hit_idx;
            multi_hit <= hit_multi;
            lru_load  <= 1'b1;
            if (req_live) begin
              mem_resp <= 1'b1;
              if (is_write_q) begin
                data_load  <= 1'b1;
                dirty_load <= 1'b1;
                dirty_in   <= 1'b1;
              end
            end
            state_q <= StIdle;
`ifdef L2_CACHE_PREFETCH_EN
            if (pf_pending_q) begin
              pf_pending_q <= 1'b0;
              paddr_sel    <= PaddrPrefetch;
              state_q      <= StPfLookup;
            end
`endif
          end else begin
            victim_q <= lru_way;
            way_sel  <= lru_way;
            if (dirty_way[lru_way]) begin
              pmem_write <= 1'b1;
              paddr_sel  <= PaddrVictim;
              state_q    <= StWriteback;
            end else begin
              pmem_read <= 1'b1;
              state_q   <= StFill;
            end
          end
        end

        StWriteback: begin
          if (!req_now) dropped_q <= 1'b1;
          way_sel <= victim_q;
          if (pmem_resp) begin
            pmem_read <= 1'b1;
            state_q   <= StFill;
          end else begin
            pmem_write <= 1'b1;
            paddr_sel  <= PaddrVictim;
          end
        end

        StFill: begin
          if (!req_now) dropped_q <= 1'b1;
          way_sel <= victim_q;
          if (pmem_resp) begin
            data_load   <= 1'b1;
            tag_load    <= 1'b1;
            valid_load  <= 1'b1;
            dirty_load  <= 1'b1;
            data_in_sel <= 1'b1;
            // Re-run the lookup so the request completes through the hit path.
            state_q     <= StLookup;
`ifdef L2_CACHE_PREFETCH_EN
            pf_addr_load_q <= 1'b1;
            pf_pending_q   <= 1'b1;
`endif
          end else begin
            pmem_read <= 1'b1;
          end
        end

`ifdef L2_CACHE_PREFETCH_EN
        // Prefetch path: no upstream response or LRU update; new requests wait.
        StPfLookup: begin
          paddr_sel <= PaddrPrefetch;
          state_q   <= StPfDecide;
        end

        StPfDecide: begin
          if (hit_any) begin
            multi_hit <= hit_multi;
            state_q   <= StIdle;
          end else begin
            victim_q <= lru_way;
            way_sel  <= lru_way;
            if (dirty_way[lru_way]) begin
              pmem_write <= 1'b1;
              paddr_sel  <= PaddrVictim;
              state_q    <= StPfWriteback;
            end else begin
              pmem_read <= 1'b1;
              paddr_sel <= PaddrPrefetch;
              state_q   <= StPfFill;
            end
          end
        end

        StPfWriteback: begin
          way_sel <= victim_q;
          if (pmem_resp) begin
            pmem_read <= 1'b1;
            paddr_sel <= PaddrPrefetch;
            state_q   <= StPfFill;
          end else begin
            pmem_write <= 1'b1;
            paddr_sel  <= PaddrVictim;
          end
        end

        StPfFill: begin
          way_sel <= victim_q;
          if (pmem_resp) begin
            data_load   <= 1'b1;
            tag_load    <= 1'b1;
            valid_load  <= 1'b1;
            dirty_load  <= 1'b1;
            data_in_sel <= 1'b1;
            state_q     <= StIdle;
          end else begin
            pmem_read <= 1'b1;
            paddr_sel <= PaddrPrefetch;
          end
        end
`endif

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache_fsm.sv
// tb_l2_cache_fsm: directed self-checking bench for l2_cache_fsm (WAYS=4).
module tb_l2_cache_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_read, mem_write, mem_resp;
  logic       pmem_read, pmem_write, pmem_resp;
  logic [3:0] hit_way, dirty_way;
  logic [1:0] lru_way, way_sel, paddr_sel;
  logic       data_load, tag_load, valid_load, dirty_load, lru_load;
  logic       dirty_in, data_in_sel, pf_addr_load, multi_hit;

  int errors = 0;
  int checks = 0;

  l2_cache_fsm #(
    .WAYS (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_resp     (mem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .hit_way      (hit_way),
    .dirty_way    (dirty_way),
    .lru_way      (lru_way),
    .way_sel      (way_sel),
    .data_load    (data_load),
    .tag_load     (tag_load),
    .valid_load   (valid_load),
    .dirty_load   (dirty_load),
    .lru_load     (lru_load),
    .dirty_in     (dirty_in),
    .data_in_sel  (data_in_sel),
    .paddr_sel    (paddr_sel),
    .pf_addr_load (pf_addr_load),
    .multi_hit    (multi_hit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {mem_resp, pmem_read, pmem_write, data, tag, valid, dirty, lru, dirty_in,
  //  data_in_sel, pf_addr_load, multi_hit, paddr_sel[1:0], way_sel[1:0]}
  function automatic logic [31:0] outs();
    return {16'd0, mem_resp, pmem_read, pmem_write, data_load, tag_load, valid_load,
            dirty_load, lru_load, dirty_in, data_in_sel, pf_addr_load, multi_hit,
            paddr_sel, way_sel};
  endfunction

  initial begin
    rst_n = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    hit_way = 4'b0000; dirty_way = 4'b0000; lru_way = 2'd0;
    tick();
    chk("reset_outs", outs(), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_outs", outs(), 32'h0);

    // Read hit on way 2: mem_resp three cycles after the request.
    mem_read = 1'b1; hit_way = 4'b0100;
    tick(); chk("rd_hit_c1_resp", mem_resp, 1'b0);
    tick(); chk("rd_hit_c2_resp", mem_resp, 1'b0);
    tick();
    chk("rd_hit_c3_resp", mem_resp, 1'b1);
    chk("rd_hit_c3_way", way_sel, 2'd2);
    chk("rd_hit_c3_lru", lru_load, 1'b1);
    chk("rd_hit_c3_data", data_load, 1'b0);
    chk("rd_hit_c3_multi", multi_hit, 1'b0);
    mem_read = 1'b0;
    tick(); chk("rd_hit_c4_outs", outs(), 32'h0);
    tick(); tick(); tick();

    // Write miss, dirty victim way 1: writeback, fill, re-lookup, write hit.
    mem_write = 1'b1; hit_way = 4'b0000; lru_way = 2'd1; dirty_way = 4'b0010;
    tick(); tick(); tick();
    chk("wm_wb_pmem_write", pmem_write, 1'b1);
    chk("wm_wb_paddr", paddr_sel, 2'd1);
    chk("wm_wb_way", way_sel, 2'd1);
    chk("wm_wb_pmem_read", pmem_read, 1'b0);
    tick();
    chk("wm_wb_hold", {pmem_write, paddr_sel}, 3'b101);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    chk("wm_fill_pmem", {pmem_read, pmem_write}, 2'b10);
    chk("wm_fill_paddr", paddr_sel, 2'd0);
    chk("wm_fill_way", way_sel, 2'd1);
    chk("wm_fill_strobes", data_load, 1'b0);
    tick();
    chk("wm_fill_hold", pmem_read, 1'b1);
    pmem_resp = 1'b1; hit_way = 4'b0010;
    tick();
    pmem_resp = 1'b0;
    // {data, tag, valid, dirty, dirty_in, data_in_sel, pmem_read}
    chk("wm_fill_done", {data_load, tag_load, valid_load, dirty_load, dirty_in,
                         data_in_sel, pmem_read}, 7'b1111010);
    chk("wm_fill_done_way", way_sel, 2'd1);
    chk("wm_fill_done_resp", mem_resp, 1'b0);
    tick();
    chk("wm_lookup_outs", outs(), 32'h0);
    tick();
    chk("wm_hit_resp", mem_resp, 1'b1);
    chk("wm_hit_write", {data_load, dirty_load, dirty_in, data_in_sel, lru_load}, 5'b11101);
    chk("wm_hit_way", way_sel, 2'd1);
    mem_write = 1'b0;
    tick(); chk("wm_after_resp", mem_resp, 1'b0);
    tick(); tick(); tick(); tick();

    // Multi-hot hit: lowest way wins, multi_hit pulses once.
    mem_read = 1'b1; hit_way = 4'b1010; dirty_way = 4'b0000;
    tick(); tick();
    chk("mh_c2_multi", multi_hit, 1'b0);
    tick();
    chk("mh_way", way_sel, 2'd1);
    chk("mh_multi", multi_hit, 1'b1);
    chk("mh_resp", mem_resp, 1'b1);
    mem_read = 1'b0;
    tick(); chk("mh_multi_clear", multi_hit, 1'b0);
    tick(); tick(); tick();

    // Clean miss on way 2 (only way 1 dirty), then reset mid-fill.
    mem_read = 1'b1; hit_way = 4'b0000; lru_way = 2'd2; dirty_way = 4'b0010;
    tick(); tick(); tick();
    chk("rst_fill_pmem", {pmem_read, pmem_write}, 2'b10);
    chk("rst_fill_way", way_sel, 2'd2);
    chk("rst_fill_paddr", paddr_sel, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_pmem_read", pmem_read, 1'b0);
    chk("rst_async_outs", outs(), 32'h0);
    mem_read = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); chk("rst_post_outs1", outs(), 32'h0);
    tick(); chk("rst_post_outs2", outs(), 32'h0);
    // Fresh read hit on way 0 must follow normal 3-cycle latency from IDLE.
    mem_read = 1'b1; hit_way = 4'b0001;
    tick(); tick();
    chk("rst_post_c2_resp", mem_resp, 1'b0);
    tick();
    chk("rst_post_c3_resp", mem_resp, 1'b1);
    chk("rst_post_c3_way", way_sel, 2'd0);
    mem_read = 1'b0;
    tick(); tick(); tick(); tick();

    // Write miss dropped during fill: fill completes, no mem_resp or CPU write.
    mem_write = 1'b1; hit_way = 4'b0000; lru_way = 2'd3; dirty_way = 4'b0000;
    tick(); tick(); tick();
    chk("drop_fill_pmem", {pmem_read, pmem_write}, 2'b10);
    chk("drop_fill_way", way_sel, 2'd3);
    mem_write = 1'b0; pmem_resp = 1'b1; hit_way = 4'b1000;
    tick();
    pmem_resp = 1'b0;
    chk("drop_fill_done", {data_load, tag_load, data_in_sel}, 3'b111);
    tick(); tick();
    chk("drop_no_resp", mem_resp, 1'b0);
    chk("drop_no_cpu_write", {data_load, dirty_in}, 2'b00);
    chk("drop_lru", lru_load, 1'b1);
    tick(); tick(); tick(); tick();

`ifdef L2_CACHE_PREFETCH_EN
    // Clean read miss on way 0, then next-line prefetch into way 3.
    mem_read = 1'b1; hit_way = 4'b0000; lru_way = 2'd0; dirty_way = 4'b0000;
    tick(); tick(); tick();
    chk("pf_fill_pmem", pmem_read, 1'b1);
    pmem_resp = 1'b1; hit_way = 4'b0001;
    tick();
    pmem_resp = 1'b0;
    chk("pf_addr_load", pf_addr_load, 1'b1);
    chk("pf_fill_done", data_load, 1'b1);
    tick(); tick();
    chk("pf_demand_resp", mem_resp, 1'b1);
    chk("pf_lookup_paddr", paddr_sel, 2'd2);
    chk("pf_demand_lru", lru_load, 1'b1);
    // A new request arrives during the prefetch and must wait for IDLE.
    hit_way = 4'b0000; lru_way = 2'd3;
    tick();
    chk("pf_decide_outs", {mem_resp, paddr_sel}, 3'b010);
    tick();
    chk("pf_pfill_pmem", pmem_read, 1'b1);
    chk("pf_pfill_paddr", paddr_sel, 2'd2);
    chk("pf_pfill_way", way_sel, 2'd3);
    chk("pf_pfill_resp", mem_resp, 1'b0);
    pmem_resp = 1'b1; hit_way = 4'b0001;
    tick();
    pmem_resp = 1'b0;
    chk("pf_pfill_done", {data_load, data_in_sel, mem_resp, lru_load, pf_addr_load},
        5'b11000);
    tick(); chk("pf_new_c1", mem_resp, 1'b0);
    tick(); chk("pf_new_c2", mem_resp, 1'b0);
    tick();
    chk("pf_new_c3_resp", mem_resp, 1'b1);
    mem_read = 1'b0;
    tick();
    chk("pf_no_chain", paddr_sel, 2'd0);
    tick(); tick();
`else
    chk("pf_tied_low", pf_addr_load, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
